// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction-fetch stage. Owns the program counter (PC) and the instruction
// register (IR), runs one memory read handshake per fetch request and presents
// the fetched 16-bit word on IRout for decode. PC redirects from the control
// unit (jump / conditional branch) are applied only while the stage is idle.
//
// Parameters
//   RESET_PC     PC value loaded on reset.
//   MEM_TIMEOUT  REQ cycles to wait for memRdy before aborting (1..255).
//
// Ports
//   clk         in   clock, all state changes on the rising edge
//   reset       in   synchronous active-low reset
//   fetchStart  in   fetch the instruction at PC (sampled in IDLE only)
//   PCwrt       in   commit a PC update (honoured in IDLE only)
//   branch      in   with PCwrt: conditional branch to target
//   jump        in   with PCwrt: unconditional jump to target (beats branch)
//   bneObeq     in   branch sense: 1 = bne, 0 = beq
//   zero        in   ALU zero flag
//   target      in   absolute redirect address
//   memDat      in   instruction word from memory
//   memRdy      in   memory data valid (sampled in REQ only)
//   memRd       out  read strobe, high for every REQ cycle
//   memAdrs     out  read address (always the PC)
//   pcOut       out  current PC
//   IRout       out  instruction register
//   irValid     out  one-cycle pulse in the cycle after the IR was loaded
//   busy        out  high in REQ and DONE
//   fetchErr    out  sticky memory-timeout flag
//   dbg_state   out  FSM state encoding (0 IDLE, 1 REQ, 2 DONE)
//
// Handshake: a read is outstanding for every cycle memRd is high; the word is
// taken on the first rising edge at which memRd and memRdy are both high.
// memRdy outside REQ has no effect.
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [15:0] RESET_PC    = 16'h0000,
    parameter int          MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetchStart,
    input  logic        PCwrt,
    input  logic        branch,
    input  logic        jump,
    input  logic        bneObeq,
    input  logic        zero,
    input  logic [15:0] target,
    input  logic [15:0] memDat,
    input  logic        memRdy,
    output logic        memRd,
    output logic [15:0] memAdrs,
    output logic [15:0] pcOut,
    output logic [15:0] IRout,
    output logic        irValid,
    output logic        busy,
    output logic        fetchErr,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Value of the wait counter during the last REQ cycle allowed before the
    // read is abandoned: the counter holds (k-1) during the k-th REQ cycle.
    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t      state;
    logic [15:0] pc;
    logic [15:0] ir;
    logic [7:0]  wait_cnt;
    logic        err;

    // Branch is taken when the zero flag matches the requested sense:
    // beq (bneObeq=0) wants zero=1, bne (bneObeq=1) wants zero=0.
    logic branch_taken;
    assign branch_taken = branch && (zero ^ bneObeq);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            pc       <= RESET_PC;
            ir       <= 16'h0000;
            wait_cnt <= 8'd0;
            err      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // A redirect and a fetch request in the same cycle both
                    // land on this edge, so the following REQ reads the new PC.
                    if (PCwrt) begin
                        if (jump) begin
                            pc <= target;
                        end else if (branch_taken) begin
                            pc <= target;
                        end
                    end
                    if (fetchStart) begin
                        state    <= REQ;
                        wait_cnt <= 8'd0;
                        err      <= 1'b0;
                    end
                end

                REQ: begin
                    if (memRdy) begin
                        ir    <= memDat;
                        pc    <= pc + 16'd2;   // wraps naturally at 16 bits
                        state <= DONE;
                    end else if (wait_cnt == WAIT_LAST) begin
                        err   <= 1'b1;
                        state <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end

                DONE: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // All outputs come straight from registers or a decode of the state
    // register; no input reaches an output combinationally.
    assign memRd     = (state == REQ);
    assign irValid   = (state == DONE);
    assign busy      = (state == REQ) || (state == DONE);
    assign memAdrs   = pc;
    assign pcOut     = pc;
    assign IRout     = ir;
    assign fetchErr  = err;
    assign dbg_state = state;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    localparam int MEM_TIMEOUT = 15;

    logic        clk;
    logic        reset;
    logic        fetchStart;
    logic        PCwrt;
    logic        branch;
    logic        jump;
    logic        bneObeq;
    logic        zero;
    logic [15:0] target;
    logic [15:0] memDat;
    logic        memRdy;
    logic        memRd;
    logic [15:0] memAdrs;
    logic [15:0] pcOut;
    logic [15:0] IRout;
    logic        irValid;
    logic        busy;
    logic        fetchErr;
    logic [1:0]  dbg_state;

    int checks = 0;
    int passes = 0;

    logic [15:0] exp_q[$];
    logic [15:0] model_pc;
    logic [15:0] model_ir;

    fetch_unit #(.RESET_PC(16'h0000), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
        .clk(clk), .reset(reset), .fetchStart(fetchStart), .PCwrt(PCwrt),
        .branch(branch), .jump(jump), .bneObeq(bneObeq), .zero(zero),
        .target(target), .memDat(memDat), .memRdy(memRdy), .memRd(memRd),
        .memAdrs(memAdrs), .pcOut(pcOut), .IRout(IRout), .irValid(irValid),
        .busy(busy), .fetchErr(fetchErr), .dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pc(input logic [15:0] addr);
        PCwrt = 1'b1; jump = 1'b1; branch = 1'b0; target = addr;
        tick();
        PCwrt = 1'b0; jump = 1'b0;
        model_pc = addr;
    endtask

    // Issue one fetch that completes after 'waits' stall cycles. With redirect
    // set, a jump to 16'h0100 is asserted throughout REQ and must be ignored.
    task automatic run_fetch(input int waits, input logic [15:0] data,
                             input bit redirect, input string name);
        int lat;
        int rd;
        bit seen;
        logic [15:0] exp_ir;
        logic [15:0] addr;
        addr = model_pc;
        fetchStart = 1'b1;
        exp_q.push_back(data);
        tick();
        fetchStart = 1'b0;
        PCwrt = 1'b0;
        checks++;
        if (fetchErr !== 1'b0) $display("FAIL %s_err_clear: fetchErr=%b expected 0", name, fetchErr);
        else passes++;
        lat = 1; rd = 0; seen = 0;
        while (!seen && lat < 60) begin
            if (memRd) begin
                rd++;
                checks++;
                if (memAdrs !== addr) $display("FAIL %s_addr: memAdrs=%h expected %h", name, memAdrs, addr);
                else passes++;
                memRdy = (rd == waits + 1);
                memDat = memRdy ? data : 16'($urandom);
                if (redirect) begin
                    PCwrt = 1'b1; jump = 1'b1; target = 16'h0100;
                end
            end else begin
                memRdy = 1'b0;
            end
            tick();
            lat++;
            memRdy = 1'b0;
            PCwrt = 1'b0; jump = 1'b0;
            if (irValid) seen = 1;
        end
        checks++;
        if (!seen) begin
            $display("FAIL %s_no_irvalid: irValid never seen after %0d cycles", name, lat);
            void'(exp_q.pop_front());
        end else begin
            passes++;
            exp_ir = exp_q.pop_front();
            checks++;
            if (IRout !== exp_ir) $display("FAIL %s_ir: IRout=%h expected %h", name, IRout, exp_ir);
            else passes++;
            checks++;
            if (lat != waits + 2) $display("FAIL %s_latency: latency=%0d expected %0d", name, lat, waits + 2);
            else passes++;
            checks++;
            if (rd != waits + 1) $display("FAIL %s_memrd_cycles: memRd cycles=%0d expected %0d", name, rd, waits + 1);
            else passes++;
            checks++;
            if (pcOut !== 16'(addr + 16'd2)) $display("FAIL %s_pc: pcOut=%h expected %h", name, pcOut, 16'(addr + 16'd2));
            else passes++;
            model_pc = 16'(addr + 16'd2);
            model_ir = data;
        end
        tick();
        checks++;
        if (irValid !== 1'b0 || busy !== 1'b0) $display("FAIL %s_pulse: irValid=%b busy=%b expected 0 0", name, irValid, busy);
        else passes++;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        model_pc = 16'h0000;
        model_ir = 16'h0000;
        checks++;
        if (pcOut !== 16'h0000 || memAdrs !== 16'h0000) $display("FAIL reset_pc: pcOut=%h memAdrs=%h expected 0000", pcOut, memAdrs);
        else passes++;
        checks++;
        if (IRout !== 16'h0000) $display("FAIL reset_ir: IRout=%h expected 0000", IRout);
        else passes++;
        checks++;
        if ({memRd, irValid, busy, fetchErr} !== 4'b0000 || dbg_state !== 2'd0)
            $display("FAIL reset_ctrl: memRd/irValid/busy/fetchErr=%b state=%0d expected 0000 0", {memRd, irValid, busy, fetchErr}, dbg_state);
        else passes++;
        tick();
        run_fetch(0, 16'h0186, 1'b0, "first_fetch");
    endtask

    task automatic test_wait_states();
        run_fetch(3, 16'h0318, 1'b0, "wait3");
        checks++;
        if (fetchErr !== 1'b0) $display("FAIL wait3_err: fetchErr=%b expected 0", fetchErr);
        else passes++;
    endtask

    task automatic test_branch();
        set_pc(16'h0010);
        PCwrt = 1; branch = 1; bneObeq = 0; zero = 1; target = 16'h0040;
        tick();
        PCwrt = 0;
        checks++;
        if (pcOut !== 16'h0040) $display("FAIL beq_taken: pcOut=%h expected 0040", pcOut);
        else passes++;
        set_pc(16'h0010);
        PCwrt = 1; branch = 1; bneObeq = 0; zero = 0; target = 16'h0040;
        tick();
        PCwrt = 0;
        checks++;
        if (pcOut !== 16'h0010) $display("FAIL beq_not_taken: pcOut=%h expected 0010", pcOut);
        else passes++;
        PCwrt = 1; branch = 1; bneObeq = 1; zero = 0; target = 16'h0080;
        tick();
        PCwrt = 0;
        checks++;
        if (pcOut !== 16'h0080) $display("FAIL bne_taken: pcOut=%h expected 0080", pcOut);
        else passes++;
        PCwrt = 0; jump = 1; branch = 1; bneObeq = 1; zero = 0; target = 16'h0300;
        tick();
        checks++;
        if (pcOut !== 16'h0080) $display("FAIL no_pcwrt: pcOut=%h expected 0080", pcOut);
        else passes++;
        PCwrt = 1; jump = 1; branch = 1; bneObeq = 0; zero = 0; target = 16'h1234;
        tick();
        PCwrt = 0; jump = 0; branch = 0;
        checks++;
        if (pcOut !== 16'h1234) $display("FAIL jump_priority: pcOut=%h expected 1234", pcOut);
        else passes++;
        model_pc = 16'h1234;
    endtask

    task automatic test_wrap();
        set_pc(16'hFFFE);
        run_fetch(1, 16'hA5A5, 1'b1, "wrap");
        checks++;
        if (pcOut !== 16'h0000) $display("FAIL wrap_pc: pcOut=%h expected 0000", pcOut);
        else passes++;
    endtask

    task automatic test_redirect_fetch();
        // Same-cycle redirect and fetch: the fetch must read the new PC.
        PCwrt = 1; jump = 1; target = 16'h0200;
        model_pc = 16'h0200;
        run_fetch(0, 16'h7E01, 1'b0, "redirect_fetch");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++) run_fetch(0, 16'(16'h1000 + i), 1'b0, "b2b");
    endtask

    task automatic test_busy_ignore();
        logic [15:0] exp_ir;
        fetchStart = 1;
        exp_q.push_back(16'hBEEF);
        tick();
        memRdy = 1; memDat = 16'hBEEF;   // fetchStart still high while busy
        tick();
        memRdy = 0;
        checks++;
        if (irValid !== 1'b1) $display("FAIL busy_ign_valid: irValid=%b expected 1", irValid);
        else passes++;
        exp_ir = exp_q.pop_front();
        checks++;
        if (IRout !== exp_ir) $display("FAIL busy_ign_ir: IRout=%h expected %h", IRout, exp_ir);
        else passes++;
        model_pc = 16'(model_pc + 16'd2);
        model_ir = exp_ir;
        tick();
        fetchStart = 0;
        tick();
        checks++;
        if (memRd !== 1'b0 || busy !== 1'b0) $display("FAIL busy_ign_queued: memRd=%b busy=%b expected 0 0", memRd, busy);
        else passes++;
    endtask

    task automatic test_timeout();
        int cnt;
        bit pulse;
        fetchStart = 1;
        tick();
        fetchStart = 0;
        memRdy = 0;
        cnt = 0; pulse = 0;
        while (memRd && cnt < 100) begin
            cnt++;
            tick();
            if (irValid) pulse = 1;
        end
        checks++;
        if (cnt != MEM_TIMEOUT) $display("FAIL timeout_len: memRd cycles=%0d expected %0d", cnt, MEM_TIMEOUT);
        else passes++;
        checks++;
        if (fetchErr !== 1'b1 || busy !== 1'b0 || pulse) $display("FAIL timeout_flags: fetchErr=%b busy=%b irValid_seen=%b expected 1 0 0", fetchErr, busy, pulse);
        else passes++;
        checks++;
        if (pcOut !== model_pc || IRout !== model_ir) $display("FAIL timeout_state: pc=%h ir=%h expected %h %h", pcOut, IRout, model_pc, model_ir);
        else passes++;
        tick();
        checks++;
        if (fetchErr !== 1'b1) $display("FAIL timeout_sticky: fetchErr=%b expected 1", fetchErr);
        else passes++;
        run_fetch(2, 16'h5A5A, 1'b0, "after_timeout");
    endtask

    task automatic test_reset_mid_fetch();
        fetchStart = 1;
        tick();
        fetchStart = 0;
        tick();                     // second REQ cycle
        reset = 0; memRdy = 1; memDat = 16'hDEAD;
        tick();
        reset = 1; memRdy = 0;
        model_pc = 16'h0000; model_ir = 16'h0000;
        checks++;
        if (memRd !== 1'b0 || busy !== 1'b0 || irValid !== 1'b0) $display("FAIL midreset_ctrl: memRd=%b busy=%b irValid=%b expected 0 0 0", memRd, busy, irValid);
        else passes++;
        checks++;
        if (pcOut !== 16'h0000 || IRout !== 16'h0000) $display("FAIL midreset_regs: pc=%h ir=%h expected 0000 0000", pcOut, IRout);
        else passes++;
        tick();
        checks++;
        if (irValid !== 1'b0) $display("FAIL midreset_pulse: irValid=%b expected 0", irValid);
        else passes++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 6; i++)
            run_fetch($urandom_range(0, 5), 16'($urandom), 1'b0, "rand");
    endtask

    // ---------------- main sequence and report ----------------
    initial begin
        reset = 0; fetchStart = 0; PCwrt = 0; branch = 0; jump = 0;
        bneObeq = 0; zero = 0; target = 0; memDat = 0; memRdy = 0;
        test_reset();
        test_wait_states();
        test_branch();
        test_wrap();
        test_redirect_fetch();
        test_back_to_back();
        test_busy_ignore();
        test_timeout();
        test_reset_mid_fetch();
        test_random();
        checks++;
        if (exp_q.size() != 0) $display("FAIL scoreboard_drain: %0d entries left expected 0", exp_q.size());
        else passes++;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
